img_mem_arbiter: RTL and testbench

- Shares one single-port processed-image memory between two requesters: the CPU datapath (read/write) and a display readout engine (read-only).
- Sits between the register-file/store path and the image memory. Replaces the direct write-enable/address hookup with a granted request channel per requester.
- Display is the real-time requester. A run-length limit bounds CPU starvation.

---
 rtl/img_mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_img_mem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/img_mem_arbiter.sv
// img_mem_arbiter
//   Shares one single-port image memory between the CPU datapath (read/write)
//   and the display readout engine (read-only). The display is the real-time
//   requester. Under contention the CPU is guaranteed a slot after at most
//   BURST_MAX consecutive display grants.
//
//   Optional build macro IMG_ARB_ROUND_ROBIN_EN: when defined, contention is
//   resolved by alternating with the previous owner, and the BURST_MAX limit
//   is not used.
//
// Ports
//   clk, rst           clock; asynchronous active-low reset
//   cpu_req/we/addr/wdata   CPU request channel (held stable until granted)
//   cpu_gnt            CPU access accepted this cycle
//   cpu_rdata/rvalid   CPU read return (rvalid is a one-cycle pulse)
//   dsp_req/addr       display read request channel
//   dsp_gnt            display access accepted this cycle
//   dsp_rdata/rvalid   display read return
//   mem_addr/we/wdata  image memory drive
//   mem_rdata          image memory read data, RD_LAT cycles after address
//   owner              debug: 00 idle, 01 CPU, 10 display (this cycle)
module img_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 16,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              dsp_req,
    input  logic [ADDR_W-1:0] dsp_addr,
    output logic              dsp_gnt,
    output logic [DATA_W-1:0] dsp_rdata,
    output logic              dsp_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    localparam logic [1:0] TAG_NONE = 2'b00;
    localparam logic [1:0] TAG_CPU  = 2'b01;
    localparam logic [1:0] TAG_DSP  = 2'b10;

    logic [1:0]        tag_p [RD_LAT];
    logic [1:0]        new_tag;
    logic [ADDR_W-1:0] addr_hold;
    logic [DATA_W-1:0] wdata_hold;
    logic [DATA_W-1:0] cpu_rdata_hold;
    logic [DATA_W-1:0] dsp_rdata_hold;
    logic              cpu_wins;

`ifdef IMG_ARB_ROUND_ROBIN_EN
    // Under contention, whoever was not granted last wins.
    logic last_dsp;

    always_comb begin
        cpu_wins = last_dsp;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_dsp <= 1'b1;
        end else if (cpu_gnt) begin
            last_dsp <= 1'b0;
        end else if (dsp_gnt) begin
            last_dsp <= 1'b1;
        end
    end
`else
    localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

    // Consecutive display grants taken while the CPU is waiting.
    logic [7:0] run_cnt;

    always_comb begin
        cpu_wins = (run_cnt >= BURST_LIM);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_cnt <= '0;
        end else if (!cpu_req || cpu_gnt) begin
            run_cnt <= '0;
        end else if (dsp_gnt && (run_cnt < BURST_LIM)) begin
            run_cnt <= run_cnt + 8'd1;
        end
    end
`endif

    // Grant selection; gated by reset so nothing transfers while held in reset.
    always_comb begin
        cpu_gnt = 1'b0;
        dsp_gnt = 1'b0;
        if (rst) begin
            if (cpu_req && dsp_req) begin
                cpu_gnt = cpu_wins;
                dsp_gnt = !cpu_wins;
            end else begin
                cpu_gnt = cpu_req;
                dsp_gnt = dsp_req;
            end
        end
    end

    assign owner = {dsp_gnt, cpu_gnt};

    // Memory drive: granted requester, otherwise hold the last address/data.
    always_comb begin
        mem_addr  = addr_hold;
        mem_wdata = wdata_hold;
        mem_we    = 1'b0;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
        end else if (dsp_gnt) begin
            mem_addr  = dsp_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_hold  <= '0;
            wdata_hold <= '0;
        end else begin
            addr_hold  <= mem_addr;
            wdata_hold <= mem_wdata;
        end
    end

    // Read-tag pipeline: a granted read enters stage 0 at the grant edge and
    // reaches the last stage exactly in the cycle its data is on mem_rdata.
    always_comb begin
        new_tag = TAG_NONE;
        if (cpu_gnt && !cpu_we) begin
            new_tag = TAG_CPU;
        end else if (dsp_gnt) begin
            new_tag = TAG_DSP;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_p[i] <= TAG_NONE;
            end
        end else begin
            tag_p[0] <= new_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_p[i] <= tag_p[i-1];
            end
        end
    end

    // Read return: data is passed straight through on the rvalid cycle and
    // captured so rdata holds until the next return for that requester.
    assign cpu_rvalid = (tag_p[RD_LAT-1] == TAG_CPU);
    assign dsp_rvalid = (tag_p[RD_LAT-1] == TAG_DSP);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_hold;
    assign dsp_rdata  = dsp_rvalid ? mem_rdata : dsp_rdata_hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rdata_hold <= '0;
            dsp_rdata_hold <= '0;
        end else begin
            if (cpu_rvalid) begin
                cpu_rdata_hold <= mem_rdata;
            end
            if (dsp_rvalid) begin
                dsp_rdata_hold <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_img_mem_arbiter.sv
// Directed bench for img_mem_arbiter with a small RD_LAT-cycle memory model.
// Unwritten memory locations read back as (addr*3+1).
module tb_img_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 8;
    localparam int BM  = 4;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          dsp_req;
    logic [AW-1:0] dsp_addr;
    logic          dsp_gnt, dsp_rvalid;
    logic [DW-1:0] dsp_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    owner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    img_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dsp_req(dsp_req), .dsp_addr(dsp_addr), .dsp_gnt(dsp_gnt),
        .dsp_rdata(dsp_rdata), .dsp_rvalid(dsp_rvalid),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    // Memory model
    logic [DW-1:0] mem [256];
    logic [255:0]  written = '0;
    logic [AW-1:0] apipe [LAT];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[7:0]]     <= mem_wdata;
            written[mem_addr[7:0]] <= 1'b1;
        end
        apipe[0] <= mem_addr;
        for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
    end

    assign mem_rdata = written[apipe[LAT-1][7:0]] ? mem[apipe[LAT-1][7:0]]
                                                  : 8'(apipe[LAT-1][7:0] * 3 + 1);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        dsp_req = 1'b0;
    endtask

    logic [11:0] pat;

    initial begin
        rst = 1'b0;
        idle();
        cpu_addr = '0; cpu_wdata = '0; dsp_addr = '0;
        tick(); tick();
        settle();
        chk("rst_cpu_gnt",    32'(cpu_gnt),    32'(0));
        chk("rst_dsp_gnt",    32'(dsp_gnt),    32'(0));
        chk("rst_mem_addr",   32'(mem_addr),   32'(0));
        chk("rst_mem_we",     32'(mem_we),     32'(0));
        chk("rst_mem_wdata",  32'(mem_wdata),  32'(0));
        chk("rst_owner",      32'(owner),      32'(0));
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'(0));
        chk("rst_dsp_rvalid", 32'(dsp_rvalid), 32'(0));
        chk("rst_cpu_rdata",  32'(cpu_rdata),  32'(0));
        chk("rst_dsp_rdata",  32'(dsp_rdata),  32'(0));

        // In-flight CPU read killed by reset
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h5;
        settle();
        chk("rst_rel_cpu_gnt", 32'(cpu_gnt), 32'(1));
        tick();
        idle();
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h99; cpu_wdata = 8'h33;
        rst = 1'b0;
        settle();
        chk("inrst_cpu_gnt",  32'(cpu_gnt),  32'(0));
        chk("inrst_mem_we",   32'(mem_we),   32'(0));
        chk("inrst_mem_addr", 32'(mem_addr), 32'(0));
        chk("inrst_owner",    32'(owner),    32'(0));
        for (int i = 0; i < 3; i++) begin
            chk("inrst_cpu_rvalid", 32'(cpu_rvalid), 32'(0));
            tick();
        end
        idle();
        rst = 1'b1;
        dsp_req = 1'b1; dsp_addr = 32'h2;
        settle();
        chk("rel_dsp_gnt",  32'(dsp_gnt),  32'(1));
        chk("rel_mem_addr", 32'(mem_addr), 32'h2);
        chk("rel_mem_we",   32'(mem_we),   32'(0));
        tick();
        idle();
        for (int i = 1; i <= 5; i++) begin
            settle();
            chk("rel_cpu_rvalid", 32'(cpu_rvalid), 32'(0));
            chk("rel_dsp_rvalid", 32'(dsp_rvalid), 32'(i == 3));
            if (i == 3) chk("rel_dsp_rdata", 32'(dsp_rdata), 32'h7);
            tick();
        end

        // Lone CPU write then read
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 8'hA5;
        settle();
        chk("wr_cpu_gnt",   32'(cpu_gnt),   32'(1));
        chk("wr_mem_we",    32'(mem_we),    32'(1));
        chk("wr_mem_addr",  32'(mem_addr),  32'h10);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'hA5);
        chk("wr_owner",     32'(owner),     32'h1);
        tick();
        idle();
        settle();
        chk("hold_mem_we",    32'(mem_we),    32'(0));
        chk("hold_mem_addr",  32'(mem_addr),  32'h10);
        chk("hold_mem_wdata", 32'(mem_wdata), 32'hA5);
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        settle();
        chk("rd_cpu_gnt", 32'(cpu_gnt), 32'(1));
        chk("rd_mem_we",  32'(mem_we),  32'(0));
        tick();
        idle();
        for (int i = 1; i <= 5; i++) begin
            settle();
            chk("rd_cpu_rvalid", 32'(cpu_rvalid), 32'(i == 3));
            chk("rd_dsp_rvalid", 32'(dsp_rvalid), 32'(0));
            if (i >= 3) chk("rd_cpu_rdata", 32'(cpu_rdata), 32'hA5);
            tick();
        end

        // Contention from a fresh reset
        rst = 1'b0;
        tick();
        rst = 1'b1;
`ifdef IMG_ARB_ROUND_ROBIN_EN
        pat = 12'b1010_1010_1010;   // bit i = 1 means display granted in cycle i
`else
        pat = 12'b1101_1110_1111;
`endif
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 8'h77;
        dsp_req = 1'b1; dsp_addr = 32'h41;
        for (int i = 0; i < 12; i++) begin
            settle();
            chk("cont_dsp_gnt", 32'(dsp_gnt), 32'(pat[i]));
            chk("cont_cpu_gnt", 32'(cpu_gnt), 32'(!pat[i]));
            chk("cont_mem_we",  32'(mem_we),  32'(!pat[i]));
            chk("cont_owner",   32'(owner),   pat[i] ? 32'h2 : 32'h1);
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) tick();

        // Interleaved reads
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 8'h11;
        tick();
        cpu_addr = 32'h30; cpu_wdata = 8'h22;
        tick();
        for (int i = 0; i < 8; i++) begin
            idle();
            if (i < 4) begin
                if (i % 2 == 0) begin
                    dsp_req = 1'b1; dsp_addr = 32'h20;
                end else begin
                    cpu_req = 1'b1; cpu_addr = 32'h30;
                end
            end
            settle();
            if (i < 4) begin
                chk("il_dsp_gnt", 32'(dsp_gnt), 32'(i % 2 == 0));
                chk("il_cpu_gnt", 32'(cpu_gnt), 32'(i % 2 == 1));
            end
            chk("il_dsp_rvalid", 32'(dsp_rvalid), 32'(i == 3 || i == 5));
            chk("il_cpu_rvalid", 32'(cpu_rvalid), 32'(i == 4 || i == 6));
            if (i >= 3) chk("il_dsp_rdata", 32'(dsp_rdata), 32'h11);
            if (i >= 4) chk("il_cpu_rdata", 32'(cpu_rdata), 32'h22);
            tick();
        end

        // Display-only streaming
        for (int i = 0; i < 12; i++) begin
            idle();
            if (i < 8) begin
                dsp_req = 1'b1; dsp_addr = 32'(i);
            end
            settle();
            if (i < 8) chk("st_dsp_gnt", 32'(dsp_gnt), 32'(1));
            chk("st_dsp_rvalid", 32'(dsp_rvalid), 32'(i >= 3 && i < 11));
            chk("st_cpu_rvalid", 32'(cpu_rvalid), 32'(0));
            if (i >= 3 && i < 11) chk("st_dsp_rdata", 32'(dsp_rdata), 32'((i - 3) * 3 + 1));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
